// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : booth_pkg
//  Brief   : Shared types and helpers for the radix-4 Booth multiplier.
//  Rev     : 1.0  initial release
// ============================================================================
package booth_pkg;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_P1   = 3'd1,
        BD_P2   = 3'd2,
        BD_M1   = 3'd3,
        BD_M2   = 3'd4
    } booth_digit_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One extra bit keeps unsigned multipliers positive; round up to even.
    function automatic int ndig(input int b_w);
        return (b_w + 2) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_mult_seq_if.sv
`default_nettype none
// ============================================================================
//  Module  : booth_r4_mult_seq_if
//  Brief   : Operand/result handshake bundle for the Booth multiplier.
//  Rev     : 1.0  initial release
// ============================================================================
interface booth_r4_mult_seq_if #(
    parameter int A_W = 11,
    parameter int B_W = 8
);
    localparam int R_W = A_W + B_W;

    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] n1;
    logic [B_W-1:0] n2;
    logic           a_signed;
    logic           b_signed;
    logic           out_valid;
    logic           out_ready;
    logic [R_W-1:0] result;

    modport master (
        output in_valid, n1, n2, a_signed, b_signed, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, n1, n2, a_signed, b_signed, out_ready,
        output in_ready, out_valid, result
    );
endinterface
`default_nettype wire

// File: rtl/booth_r4_enc.sv
`default_nettype none
// ============================================================================
//  Module  : booth_r4_enc
//  Brief   : Radix-4 Booth recoder, 3-bit window to signed digit.
//  Rev     : 1.0  initial release
// ============================================================================
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0]   i_win,
    output booth_digit_e o_digit
);

    always_comb begin
        o_digit = BD_ZERO;
        case (i_win)
            3'b001, 3'b010: o_digit = BD_P1;
            3'b011:         o_digit = BD_P2;
            3'b100:         o_digit = BD_M2;
            3'b101, 3'b110: o_digit = BD_M1;
            default:        o_digit = BD_ZERO;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/booth_r4_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module  : booth_r4_mult_seq
//  Brief   : Sequential radix-4 Booth multiplier, one digit per clock.
//  Rev     : 1.0  initial release
// ============================================================================
module booth_r4_mult_seq
    import booth_pkg::*;
#(
    parameter int A_W = 11,
    parameter int B_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    booth_r4_mult_seq_if.slave  bus
);

    localparam int NDIG  = ndig(B_W);
    localparam int BE    = 2 * NDIG;
    localparam int R_W   = A_W + B_W;
    localparam int CNT_W = $clog2(NDIG);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [R_W-1:0]   r_a;
    logic [R_W-1:0]   r_acc;
    logic [R_W-1:0]   w_pp;
    logic [R_W-1:0]   w_a_ext;
    logic [BE:0]      r_b;
    logic [BE-1:0]    w_b_ext;
    booth_digit_e     w_digit;
    logic             w_accept;
    logic             w_last;
    logic             w_take;

    assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
    assign w_last   = (r_cnt == CNT_W'(NDIG - 1));
    assign w_take   = (r_state == ST_DONE) && bus.out_ready;

    assign w_a_ext = bus.a_signed ? {{(R_W-A_W){bus.n1[A_W-1]}}, bus.n1}
                                  : {{(R_W-A_W){1'b0}}, bus.n1};
    assign w_b_ext = bus.b_signed ? {{(BE-B_W){bus.n2[B_W-1]}}, bus.n2}
                                  : {{(BE-B_W){1'b0}}, bus.n2};

    // r_b carries the implicit b[-1]=0 in bit 0, so the window is always r_b[2:0].
    booth_r4_enc u_enc (
        .i_win   (r_b[2:0]),
        .o_digit (w_digit)
    );

    always_comb begin
        w_pp = '0;
        case (w_digit)
            BD_P1:   w_pp = r_a;
            BD_P2:   w_pp = {r_a[R_W-2:0], 1'b0};
            BD_M1:   w_pp = '0 - r_a;
            BD_M2:   w_pp = '0 - {r_a[R_W-2:0], 1'b0};
            default: w_pp = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_CALC;
            ST_CALC: if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE: if (w_take)   w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a   <= w_a_ext;
                        r_b   <= {w_b_ext, 1'b0};
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_CALC: begin
                    r_acc <= r_acc + w_pp;
                    r_a   <= r_a << 2;
                    r_b   <= {2'b00, r_b[BE:2]};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.result    = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_booth_r4_mult_seq
//  Brief   : Scoreboard bench for the sequential Booth multiplier.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_booth_r4_mult_seq;

    localparam int A_W  = 11;
    localparam int B_W  = 8;
    localparam int R_W  = 19;
    localparam int NDIG = 5;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   bp_mode = 0;   // 0: always ready, 1: random, 2: stalled

    logic [R_W-1:0] sb_q[$];
    int             acc_q[$];

    booth_r4_mult_seq_if #(.A_W(A_W), .B_W(B_W)) bus ();

    booth_r4_mult_seq #(.A_W(A_W), .B_W(B_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [R_W-1:0] ref_mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                               input logic as, input logic bs);
        longint av, bv, p;
        av = as ? longint'($signed(a)) : longint'(a);
        bv = bs ? longint'($signed(b)) : longint'(b);
        p  = av * bv;
        return p[R_W-1:0];
    endfunction

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: latency on each out_valid rise, result on each accepted output.
    initial begin
        int   a0;
        logic prev_ov;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (bus.out_valid === 1'b1 && prev_ov !== 1'b1) begin
                    if (acc_q.size() == 0) begin
                        chk("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        a0 = acc_q.pop_front();
                        chk("latency", 32'(cyc - a0), 32'(NDIG));
                    end
                end
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                    if (sb_q.size() == 0)
                        chk("unexpected_result", 32'd1, 32'd0);
                    else
                        chk("result", 32'(bus.result), 32'(sb_q.pop_front()));
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                         input logic as, input logic bs,
                         input logic [R_W-1:0] exp, input bit push);
        int waited;
        waited       = 0;
        bus.n1       = a;
        bus.n2       = b;
        bus.a_signed = as;
        bus.b_signed = bs;
        bus.in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            waited++;
            if (waited > 200) begin
                chk("accept_timeout", 32'd1, 32'd0);
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        if (push) begin
            sb_q.push_back(exp);
            acc_q.push_back(cyc);
        end
        bus.in_valid = 1'b0;
        bus.n1       = A_W'($urandom);
        bus.n2       = B_W'($urandom);
        bus.a_signed = 1'($urandom);
        bus.b_signed = 1'($urandom);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb_q.size() != 0 && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [A_W-1:0] pick_a();
        logic [A_W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = 11'h400;
            2:       v = 11'h7FF;
            3:       v = 11'h3FF;
            default: v = A_W'($urandom);
        endcase
        return v;
    endfunction

    function automatic logic [B_W-1:0] pick_b();
        logic [B_W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = 8'h80;
            2:       v = 8'hFF;
            3:       v = 8'h7F;
            default: v = B_W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        logic seen_ov;
        logic [A_W-1:0] ra;
        logic [B_W-1:0] rb;
        logic ras, rbs;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.n1       = '0;
        bus.n2       = '0;
        bus.a_signed = 1'b0;
        bus.b_signed = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result",    32'(bus.result),    32'd0);
        @(posedge clk);
        #1;

        bp_mode = 0;
        issue(11'h400, 8'h80, 1'b1, 1'b1, 19'h20000, 1'b1);
        drain();
        issue(11'h7FF, 8'hFF, 1'b0, 1'b0, 19'h7F701, 1'b1);
        drain();
        issue(11'h7FF, 8'hFF, 1'b1, 1'b0, 19'h7FF01, 1'b1);
        drain();
        issue(11'h400, 8'h7F, 1'b1, 1'b1, 19'h60400, 1'b1);
        drain();

        // Backpressure with ignored in_valid pulses during CALC.
        bp_mode = 2;
        issue(11'd100, 8'hFD, 1'b1, 1'b1, 19'h7FED4, 1'b1);
        bus.in_valid = 1'b1;
        bus.n1       = 11'h123;
        bus.n2       = 8'h45;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("calc_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        begin
            int w;
            w = 0;
            while (bus.out_valid !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (bus.out_valid !== 1'b1) chk("bp_valid_timeout", 32'd1, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_result",    32'(bus.result),    32'h7FED4);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        @(posedge clk);
        #1;
        bp_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("post_take_in_ready",  32'(bus.in_ready),  32'd1);
        chk("post_take_out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_sb_empty",         32'(sb_q.size()),   32'd0);
        @(posedge clk);
        #1;

        // Reset while cnt == 2 aborts the operation.
        issue(11'd7, 8'd9, 1'b1, 1'b1, 19'd0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        seen_ov = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen_ov = 1'b1;
        end
        chk("abort_no_valid", 32'(seen_ov), 32'd0);
        @(posedge clk);
        #1;
        issue(11'd3, 8'd5, 1'b1, 1'b1, 19'h0000F, 1'b1);
        drain();

        // Random operands, modes and output backpressure.
        bp_mode = 1;
        for (int i = 0; i < 2000; i++) begin
            ra  = pick_a();
            rb  = pick_b();
            ras = 1'($urandom);
            rbs = 1'($urandom);
            issue(ra, rb, ras, rbs, ref_mul(ra, rb, ras, rbs), 1'b1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
